// File: rtl/sort_loader.sv
// Serial-to-parallel frame loader feeding the odd-even transposition sorter.
// States: FILL collect elements | PAD fill tail slots | SORT start held | RELEASE wait sort_valid low
module sort_loader #(
  parameter int                   BIT_WIDTH = 8,
  parameter int                   SEQ_WIDTH = 16,
  parameter int                   CNT_WIDTH = 5,
  parameter logic [BIT_WIDTH-1:0] PAD_VALUE = '1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           s_last,
  output logic [BIT_WIDTH*SEQ_WIDTH-1:0] in,
  output logic                           start,
  input  logic                           sort_valid,
  output logic [CNT_WIDTH-1:0]           count,
  output logic                           busy
);

  localparam int IDX_W = $clog2(SEQ_WIDTH);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_PAD     = 2'd1,
    ST_SORT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   armed_q, armed_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic [BIT_WIDTH-1:0]   slot_q [SEQ_WIDTH];
  logic [BIT_WIDTH-1:0]   slot_d [SEQ_WIDTH];

  assign s_ready = (state_q == ST_FILL) && !reset;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    armed_d = armed_q;
    slot_d  = slot_q;
    case (state_q)
      ST_FILL: begin
        if (s_valid && s_ready) begin
          slot_d[count_q[IDX_W-1:0]] = s_data;
          count_d = count_q + 1'b1;
          if (count_q == CNT_WIDTH'(SEQ_WIDTH - 1)) begin
            state_d = ST_SORT;
            armed_d = 1'b0;
          end else if (s_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        for (int k = 0; k < SEQ_WIDTH; k++) begin
          if (k >= int'(count_q)) slot_d[k] = PAD_VALUE;
        end
        state_d = ST_SORT;
        armed_d = 1'b0;
      end
      ST_SORT: begin
        // First SORT cycle never completes, so a stale sort_valid is ignored.
        if (armed_q && sort_valid) state_d = ST_RELEASE;
        else                       armed_d = 1'b1;
      end
      ST_RELEASE: begin
        if (!sort_valid) begin
          state_d = ST_FILL;
          count_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
    start_d = (state_d == ST_SORT);
    busy_d  = (state_d != ST_FILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      count_q <= '0;
      armed_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < SEQ_WIDTH; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      armed_q <= armed_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      slot_q  <= slot_d;
    end
  end

  for (genvar k = 0; k < SEQ_WIDTH; k++) begin : g_pack
    assign in[BIT_WIDTH*k +: BIT_WIDTH] = slot_q[k];
  end

  assign start = start_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule
